dmem_access_ctrl: RTL and testbench

//  Shares the single-ported data memory (dmem) between two requesters: port 0 = pipeline MEM stage,

---
 rtl/dmem_ctrl_pkg.sv | 40 ++++
 rtl/dmem_access_ctrl_arbiter.sv | 58 +++++
 rtl/dmem_access_ctrl.sv | 129 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared size codes, FSM encodings and request payload type
// for the two-port data-memory access controller.
`default_nettype none

package dmem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;
  localparam logic [1:0] SIZE_RSVD = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } dmem_req_t;

  function automatic dmem_req_t pack_req(input logic        we,
                                         input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         input logic [1:0]  size,
                                         input logic        sign);
    dmem_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.size  = size;
    r.sign  = sign;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_access_ctrl_arbiter.sv
// dmem_port_arbiter: fixed priority to port 0 with a saturating starvation
// counter that forces a port-1 grant after STARVE_LIMIT consecutive port-0 wins.
`default_nettype none

module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p0_req_i,
  input  logic p1_req_i,
  input  logic take_i,
  output logic grant_id_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             w_starved;

  assign w_starved = (starve_cnt_q == LIMIT);

  always_comb begin
    grant_id_o = 1'b0;
    if (p0_req_i && p1_req_i) begin
      grant_id_o = w_starved;
    end else if (p1_req_i) begin
      grant_id_o = 1'b1;
    end
  end

  // Counter only measures an unbroken run of port-1 waiting; any gap in p1_req resets it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p1_req_i) begin
      starve_cnt_d = '0;
    end else if (take_i) begin
      if (grant_id_o) begin
        starve_cnt_d = '0;
      end else if (!w_starved) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: shares a single-ported dmem between the MEM stage (port 0)
// and the loader/debug port (port 1); IDLE -> ACCESS -> RESP per transaction.
`default_nettype none

module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic [1:0]  p0_size_i,
  input  logic        p0_sign_i,
  output logic        p0_ack_o,
  output logic [31:0] p0_rdata_o,
  output logic        p0_err_o,

  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  input  logic [1:0]  p1_size_i,
  input  logic        p1_sign_i,
  output logic        p1_ack_o,
  output logic [31:0] p1_rdata_o,
  output logic        p1_err_o,

  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_dsize_o,
  output logic        mem_dsign_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  dmem_req_t   req_q;
  logic        grant_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        w_take;
  logic        w_grant;
  dmem_req_t   w_sel_req;
  logic        w_in_access;
  logic        w_in_resp;
  logic        w_rsvd;
  logic        w_acc_err;

  assign w_take      = (state_q == ST_IDLE) && (p0_req_i || p1_req_i);
  assign w_in_access = (state_q == ST_ACCESS);
  assign w_in_resp   = (state_q == ST_RESP);

  dmem_port_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arbiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_req_i   (p0_req_i),
    .p1_req_i   (p1_req_i),
    .take_i     (w_take),
    .grant_id_o (w_grant)
  );

  assign w_sel_req = w_grant
                   ? pack_req(p1_we_i, p1_addr_i, p1_wdata_i, p1_size_i, p1_sign_i)
                   : pack_req(p0_we_i, p0_addr_i, p0_wdata_i, p0_size_i, p0_sign_i);

  // The reserved size code is rejected here, so dmem never needs to understand it.
  assign w_rsvd    = (req_q.size == SIZE_RSVD);
  assign w_acc_err = mem_err_i || w_rsvd;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_take) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      grant_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_take) begin
        req_q   <= w_sel_req;
        grant_q <= w_grant;
      end
      if (w_in_access) begin
        rdata_q <= w_acc_err ? 32'h0 : mem_rdata_i;
        err_q   <= w_acc_err;
      end
    end
  end

  // Address/data/size stay on the last latched request between accesses to avoid idle toggling.
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_dsize_o = req_q.size;
  assign mem_dsign_o = req_q.sign;
  assign mem_we_o    = w_in_access && req_q.we && !mem_err_i && !w_rsvd;

  assign p0_ack_o   = w_in_resp && !grant_q;
  assign p0_rdata_o = p0_ack_o ? rdata_q : 32'h0;
  assign p0_err_o   = p0_ack_o && err_q;

  assign p1_ack_o   = w_in_resp && grant_q;
  assign p1_rdata_o = p1_ack_o ? rdata_q : 32'h0;
  assign p1_err_o   = p1_ack_o && err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and randomized checks of dmem_access_ctrl against
// a little-endian byte memory and a transaction-level reference model.
`default_nettype none

module tb_dmem_access_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_clr;

  logic        p0_req, p0_we, p0_sign, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [1:0]  p0_size;
  logic        p1_req, p1_we, p1_sign, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [1:0]  p1_size;

  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_dsign, mem_err;
  logic [1:0]  mem_dsize;

  logic [7:0]  dm      [0:16383];
  logic [7:0]  ref_mem [0:16383];
  logic [13:0] ra;
  logic [7:0]  b0, b1, b2, b3;

  int checks   = 0;
  int failures = 0;

  always #2 clk = ~clk;

  dmem_access_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_size_i(p0_size), .p0_sign_i(p0_sign), .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata),
    .p0_err_o(p0_err),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_size_i(p1_size), .p1_sign_i(p1_sign), .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
    .p1_err_o(p1_err),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_dsize_o(mem_dsize), .mem_dsign_o(mem_dsign),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  // dmem: little-endian, combinational read with sign extension, misalignment flag
  always_comb begin
    ra = mem_addr[13:0];
    b0 = dm[ra];
    b1 = dm[ra + 14'd1];
    b2 = dm[ra + 14'd2];
    b3 = dm[ra + 14'd3];
    mem_err = ((mem_dsize == 2'b01) && mem_addr[0]) ||
              ((mem_dsize == 2'b11) && (mem_addr[1:0] != 2'b00));
    case (mem_dsize)
      2'b00:   mem_rdata = mem_dsign ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   mem_rdata = mem_dsign ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      default: mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) dm[i] <= 8'h00;
    end else if (mem_we) begin
      dm[mem_addr[13:0]] <= mem_wdata[7:0];
      if (mem_dsize != 2'b00) dm[mem_addr[13:0] + 14'd1] <= mem_wdata[15:8];
      if (mem_dsize == 2'b11) begin
        dm[mem_addr[13:0] + 14'd2] <= mem_wdata[23:16];
        dm[mem_addr[13:0] + 14'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: what a transaction should return and how it changes memory.
  task automatic ref_apply(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sign,
                           output logic [31:0] rd, output logic er);
    int n;
    int base;
    logic [31:0] v;
    n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = int'(addr[13:0]);
    er   = (size == 2'b10) || ((int'(addr[13:0]) % n) != 0);
    rd   = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (sign && (n < 4) && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
        rd = v;
      end
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sign);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_size = size; p0_sign = sign;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_size = size; p1_sign = sign;
    end
  endtask

  // One uncontested transaction, starting from an IDLE cycle.
  task automatic txn(input int port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic sign,
                     output logic [31:0] obs_rd, output logic obs_err);
    logic [31:0] e_rd;
    logic        e_err;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata, size, sign);
    ref_apply(we, addr, wdata, size, sign, e_rd, e_err);
    @(negedge clk);
    check("access_ack", 32'(port == 0 ? p0_ack : p1_ack), 32'd0);
    check("access_we", 32'(mem_we), 32'(we & ~e_err));
    check("access_addr", mem_addr, addr);
    @(negedge clk);
    obs_rd  = (port == 0) ? p0_rdata : p1_rdata;
    obs_err = (port == 0) ? p0_err : p1_err;
    check("resp_ack", 32'(port == 0 ? p0_ack : p1_ack), 32'd1);
    check("resp_err", 32'(obs_err), 32'(e_err));
    if (!we) check("resp_rdata", obs_rd, e_rd);
    check("resp_other_flags", 32'(port == 0 ? {p1_ack, p1_err} : {p0_ack, p0_err}), 32'd0);
    check("resp_other_rdata", (port == 0) ? p1_rdata : p0_rdata, 32'h0);
    check("resp_we", 32'(mem_we), 32'd0);
    drive(port, 1'b0, we, addr, wdata, size, sign);
  endtask

  initial begin
    logic [31:0] rd, e_rd;
    logic        er, e_err;
    logic        pw  [2];
    logic [31:0] pad [2];
    logic [31:0] pwd [2];
    logic [1:0]  psz [2];
    logic        psg [2];
    int          exp_cnt, acks, p1_acks, g, exp_g;

    rst_n   = 1'b0;
    mem_clr = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 16384; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;

    // byte/byte/half stores then word load
    txn(0, 1'b1, 32'h2000, 32'h0000_00ef, 2'b00, 1'b0, rd, er);
    txn(0, 1'b1, 32'h2001, 32'h0000_00be, 2'b00, 1'b0, rd, er);
    txn(0, 1'b1, 32'h2002, 32'h0000_dead, 2'b01, 1'b0, rd, er);
    txn(0, 1'b0, 32'h2000, 32'h0, 2'b11, 1'b0, rd, er);
    check("t1_word", rd, 32'hdeadbeef);
    @(negedge clk);
    check("idle_addr_hold", mem_addr, 32'h2000);
    check("idle_we", 32'(mem_we), 32'd0);

    // misaligned word store must not write
    txn(0, 1'b1, 32'h2002, 32'h0000_beef, 2'b11, 1'b0, rd, er);
    check("t2_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h2000, 32'h0, 2'b11, 1'b0, rd, er);
    check("t2_unchanged", rd, 32'hdeadbeef);

    // sign handling on port 1, reserved size on port 0
    txn(1, 1'b0, 32'h2002, 32'h0, 2'b01, 1'b1, rd, er);
    check("t3_half_signed", rd, 32'hffffdead);
    txn(1, 1'b0, 32'h2002, 32'h0, 2'b01, 1'b0, rd, er);
    check("t3_half_unsigned", rd, 32'h0000dead);
    txn(1, 1'b0, 32'h2000, 32'h0, 2'b00, 1'b1, rd, er);
    check("t3_byte_signed", rd, 32'hffffffef);
    txn(0, 1'b1, 32'h2000, 32'h1111_1111, 2'b10, 1'b0, rd, er);
    check("t3_rsvd_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h2000, 32'h0, 2'b11, 1'b0, rd, er);
    check("t3_rsvd_nowrite", rd, 32'hdeadbeef);

    // randomized single-port traffic
    for (int k = 0; k < 24; k++) begin
      txn(int'($urandom_range(0, 1)), 1'($urandom), 32'h2010 + $urandom_range(0, 47),
          $urandom, 2'($urandom), 1'($urandom), rd, er);
    end

    // both ports requesting continuously
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      pw[p] = 1'($urandom); pad[p] = 32'h2010 + $urandom_range(0, 47); pwd[p] = $urandom;
      psz[p] = 2'($urandom); psg[p] = 1'($urandom);
      drive(p, 1'b1, pw[p], pad[p], pwd[p], psz[p], psg[p]);
    end
    exp_cnt = 0; acks = 0; p1_acks = 0;
    for (int cyc = 0; cyc < 200 && acks < 12; cyc++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        g = p1_ack ? 1 : 0;
        exp_g = (exp_cnt == LIMIT) ? 1 : 0;
        check("arb_dual_ack", 32'(p0_ack & p1_ack), 32'd0);
        check("arb_grant", 32'(g), 32'(exp_g));
        ref_apply(pw[g], pad[g], pwd[g], psz[g], psg[g], e_rd, e_err);
        check("arb_err", 32'(g == 1 ? p1_err : p0_err), 32'(e_err));
        if (!pw[g]) check("arb_rdata", (g == 1) ? p1_rdata : p0_rdata, e_rd);
        if (g == 1) begin
          exp_cnt = 0;
          p1_acks++;
        end else if (exp_cnt < LIMIT) begin
          exp_cnt++;
        end
        acks++;
        pw[g] = 1'($urandom); pad[g] = 32'h2010 + $urandom_range(0, 47); pwd[g] = $urandom;
        psz[g] = 2'($urandom); psg[g] = 1'($urandom);
        drive(g, 1'b1, pw[g], pad[g], pwd[g], psz[g], psg[g]);
      end
    end
    check("arb_ack_count", 32'(acks), 32'd12);
    check("arb_p1_count", 32'(p1_acks), 32'd2);
    p0_req = 1'b0;
    p1_req = 1'b0;

    // reset during ACCESS aborts the store
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h2004, 32'h1234_5678, 2'b11, 1'b0);
    @(negedge clk);
    check("t5_we_access", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_we_rst", 32'(mem_we), 32'd0);
    check("t5_addr_rst", mem_addr, 32'h0);
    check("t5_wdata_rst", mem_wdata, 32'h0);
    check("t5_dsize_rst", 32'({mem_dsize, mem_dsign}), 32'd0);
    p0_req = 1'b0;
    @(negedge clk);
    check("t5_no_ack", 32'({p0_ack, p1_ack}), 32'd0);
    @(negedge clk);
    check("t5_no_ack2", 32'({p0_ack, p1_ack}), 32'd0);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h2004, 32'h0, 2'b11, 1'b0, rd, er);
    check("t5_mem_clean", rd, 32'h0);

    // port 1 holds req past its ack with a fresh load
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h2000, 32'h0, 2'b11, 1'b0);
    ref_apply(1'b0, 32'h2000, 32'h0, 2'b11, 1'b0, e_rd, e_err);
    @(negedge clk);
    check("t6_ack_early", 32'(p1_ack), 32'd0);
    @(negedge clk);
    check("t6_ack1", 32'(p1_ack), 32'd1);
    check("t6_rdata1", p1_rdata, e_rd);
    drive(1, 1'b1, 1'b0, 32'h2004, 32'h0, 2'b11, 1'b0);
    ref_apply(1'b0, 32'h2004, 32'h0, 2'b11, 1'b0, e_rd, e_err);
    @(negedge clk);
    check("t6_no_dup", 32'(p1_ack), 32'd0);
    @(negedge clk);
    check("t6_access2", 32'(p1_ack), 32'd0);
    check("t6_addr2", mem_addr, 32'h2004);
    @(negedge clk);
    check("t6_ack2", 32'(p1_ack), 32'd1);
    check("t6_rdata2", p1_rdata, e_rd);
    p1_req = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'(p1_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
